uart_sum_sequencer: RTL
=======================

UART_SUM_SEQUENCER -- requirements
Module: uart_sum_sequencer

Interface
REQ-001 The block SHALL have parameter N_DATA_BITS, default 8, giving the byte width on the rx and tx sides.
REQ-002 The block SHALL have parameter FRAME_LEN, default 16, legal 1..256, giving the number of bytes per frame.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_rx_data, input, N_DATA_BITS: the received byte from uart_rx.
REQ-006 The block SHALL have port i_rx_data_valid, input, 1 bit: one-cycle strobe qualifying i_rx_data.
REQ-007 The block SHALL have port i_tx_ready, input, 1 bit: uart_tx idle/ready level.
REQ-008 The block SHALL have port o_tx_data, output, N_DATA_BITS: the byte offered to uart_tx.
REQ-009 The block SHALL have port o_tx_data_valid, output, 1 bit: the tx request.
REQ-010 The block SHALL have port o_sum, output, N_DATA_BITS: the running frame sum, for the display.
REQ-011 The block SHALL have port o_frame_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-012 The block SHALL have port o_busy, output, 1 bit: high in every state except COLLECT.
REQ-013 The block SHALL have port o_overrun, output, 1 bit: sticky flag set when an rx byte is dropped.

Function
REQ-014 The FSM SHALL have the states COLLECT, TX_REQ, TX_WAIT and DONE; COLLECT is the reset state.
REQ-015 In COLLECT, each i_rx_data_valid cycle SHALL write i_rx_data to buffer[count], add it to the sum modulo 2^N_DATA_BITS (carry discarded) and increment count.
REQ-016 o_sum SHALL reflect the updated sum on the cycle after the accepting edge.
REQ-017 When the accepted byte makes count equal FRAME_LEN, the FSM SHALL move to TX_REQ on the same edge.
REQ-018 In TX_REQ, o_tx_data_valid SHALL be high and o_tx_data SHALL be stable.
REQ-019 A transfer SHALL occur on the edge where o_tx_data_valid and i_tx_ready are both high; o_tx_data_valid SHALL then drop and the FSM SHALL go to TX_WAIT.
REQ-020 TX_WAIT SHALL wait for i_tx_ready low and then high again before issuing the next byte or entering DONE.
REQ-021 If i_tx_ready is already low on the edge after the transfer, the low phase SHALL count as seen.
REQ-022 The transmitted sequence SHALL follow REQ-036/REQ-037.
REQ-023 DONE SHALL last exactly one cycle, pulse o_frame_done, clear sum and count to 0 and return to COLLECT.
REQ-024 o_sum SHALL hold the frame sum through TX_REQ and TX_WAIT, and SHALL read 0 from the cycle after DONE.
REQ-025 An i_rx_data_valid outside COLLECT SHALL be dropped: buffer, sum and count unchanged, and o_overrun set.
REQ-026 o_overrun SHALL clear only on reset.
REQ-027 An i_rx_data_valid in the DONE cycle SHALL be dropped and flagged in the same way.
REQ-028 For FRAME_LEN=1, the first byte accepted SHALL go straight to TX_REQ.
REQ-029 count SHALL be $clog2(FRAME_LEN+1) bits wide and SHALL never exceed FRAME_LEN.
REQ-030 o_tx_data_valid SHALL never be high for two consecutive transfers without a TX_WAIT in between.

Reset
REQ-031 When i_reset is high at an edge, state SHALL be COLLECT and count and sum SHALL be 0.
REQ-032 On reset, o_tx_data_valid, o_frame_done, o_busy and o_overrun SHALL be 0, and o_tx_data and o_sum SHALL be 0.
REQ-033 Reset SHALL take priority over i_rx_data_valid and over the tx handshake.
REQ-034 A reset during TX_REQ or TX_WAIT SHALL abandon the frame and issue no further tx request.
REQ-035 The buffer contents SHALL be don't-care after reset and are never read before being rewritten.

Configuration
REQ-036 Macro UART_SUM_ECHO_EN defined: each frame SHALL transmit buffer[0]..buffer[FRAME_LEN-1] in order, then the sum (FRAME_LEN+1 transfers), each using the TX_REQ/TX_WAIT handshake; a byte index SHALL sequence the buffer reads.
REQ-037 Macro UART_SUM_ECHO_EN undefined: each frame SHALL transmit only the sum (one transfer); the buffer and byte index are not instantiated.

Verification
REQ-038 FRAME_LEN=16, bytes 0x01..0x10, i_tx_ready=1: o_sum=0x88, one transfer of 0x88, o_frame_done pulses once, then o_sum=0.
REQ-039 16 bytes of 0xFF: o_sum=0xF0 (wrap), transmitted byte 0xF0.
REQ-040 i_tx_ready held 0 for 50 cycles after the frame fills: o_tx_data_valid=1 with o_tx_data=0x88 stable for 50 cycles, then a single transfer. An rx strobe with 0x55 during this time sets o_overrun=1 and o_sum stays 0x88.
REQ-041 Reset after 5 of the bytes 0x01..0x05 are accepted (o_sum=0x0F): next cycle o_sum=0 and the FSM is in COLLECT; a new 16-byte frame 0x01..0x10 yields 0x88.
REQ-042 With UART_SUM_ECHO_EN and bytes 0x01..0x10: the tx sequence is 0x01,0x02,...,0x10,0x88 (17 transfers), with i_tx_ready toggling low for 3 cycles after each transfer.

Source files
------------

// File: rtl/uart_sum_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_sum_sequencer
// Brief    : Collects FRAME_LEN bytes from uart_rx, keeps a modulo-2^N running
//            sum and sends the sum to uart_tx through a ready/valid handshake.
//            Define UART_SUM_ECHO_EN to echo the frame bytes before the sum.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sum_sequencer #(
    parameter int N_DATA_BITS = 8,
    parameter int FRAME_LEN   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [N_DATA_BITS-1:0] i_rx_data,
    input  logic                   i_rx_data_valid,
    input  logic                   i_tx_ready,
    output logic [N_DATA_BITS-1:0] o_tx_data,
    output logic                   o_tx_data_valid,
    output logic [N_DATA_BITS-1:0] o_sum,
    output logic                   o_frame_done,
    output logic                   o_busy,
    output logic                   o_overrun
);

    localparam int                c_cnt_w      = $clog2(FRAME_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_last_count = c_cnt_w'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_TX_REQ  = 2'd1,
        S_TX_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_cnt_w-1:0]     r_count;
    logic [N_DATA_BITS-1:0] r_sum;
    logic [N_DATA_BITS-1:0] r_tx_data;
    logic                   r_overrun;
    logic                   r_low_seen;

    logic [N_DATA_BITS-1:0] w_sum_next;
    logic [N_DATA_BITS-1:0] w_first_tx;
    logic [N_DATA_BITS-1:0] w_next_tx;
    logic                   w_accept;
    logic                   w_fill;
    logic                   w_xfer;
    logic                   w_wait_done;
    logic                   w_more;

    assign w_accept    = (r_state == S_COLLECT) && i_rx_data_valid;
    assign w_sum_next  = r_sum + i_rx_data;
    assign w_fill      = w_accept && (r_count == c_last_count);
    assign w_xfer      = (r_state == S_TX_REQ) && i_tx_ready;
    // The ready low phase must have been seen before a high level counts.
    assign w_wait_done = (r_state == S_TX_WAIT) && r_low_seen && i_tx_ready;

`ifdef UART_SUM_ECHO_EN
    localparam int                 c_addr_w    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_frame_len = c_cnt_w'(FRAME_LEN);

    logic [N_DATA_BITS-1:0] r_buffer [FRAME_LEN];
    logic [c_cnt_w-1:0]     r_idx;
    logic [c_cnt_w-1:0]     w_idx_inc;

    assign w_idx_inc = r_idx + c_cnt_w'(1);
    assign w_more    = (r_idx != c_frame_len);
    // With a one-byte frame buffer[0] is being written on the filling edge.
    assign w_first_tx = (r_count == '0) ? i_rx_data : r_buffer[0];
    assign w_next_tx  = (w_idx_inc == c_frame_len) ? r_sum
                                                   : r_buffer[w_idx_inc[c_addr_w-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_buffer[r_count[c_addr_w-1:0]] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx <= '0;
        end else if (w_fill) begin
            r_idx <= '0;
        end else if (w_wait_done && w_more) begin
            r_idx <= w_idx_inc;
        end
    end
`else
    assign w_more     = 1'b0;
    assign w_first_tx = w_sum_next;
    assign w_next_tx  = r_sum;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_COLLECT: if (w_fill)      w_state_next = S_TX_REQ;
            S_TX_REQ:  if (w_xfer)      w_state_next = S_TX_WAIT;
            S_TX_WAIT: if (w_wait_done) w_state_next = w_more ? S_TX_REQ : S_DONE;
            S_DONE:                     w_state_next = S_COLLECT;
            default:                    w_state_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count    <= '0;
            r_sum      <= '0;
            r_tx_data  <= '0;
            r_overrun  <= 1'b0;
            r_low_seen <= 1'b0;
        end else begin
            if (w_accept) begin
                r_count <= r_count + c_cnt_w'(1);
                r_sum   <= w_sum_next;
            end else if (r_state == S_DONE) begin
                r_count <= '0;
                r_sum   <= '0;
            end

            if (i_rx_data_valid && !w_accept) begin
                r_overrun <= 1'b1;
            end

            if (w_fill) begin
                r_tx_data <= w_first_tx;
            end else if (w_wait_done && w_more) begin
                r_tx_data <= w_next_tx;
            end

            if (w_xfer) begin
                r_low_seen <= 1'b0;
            end else if ((r_state == S_TX_WAIT) && !i_tx_ready) begin
                r_low_seen <= 1'b1;
            end
        end
    end

    assign o_tx_data       = r_tx_data;
    assign o_tx_data_valid = (r_state == S_TX_REQ);
    assign o_sum           = r_sum;
    assign o_frame_done    = (r_state == S_DONE);
    assign o_busy          = (r_state != S_COLLECT);
    assign o_overrun       = r_overrun;

endmodule
`default_nettype wire
